mux48_serial_ctrl: RTL and testbench
====================================

# mux48_serial_ctrl

Sequencing controller for the DCT stage's 48-to-1 bit multiplexer. It accepts 48-bit packed coefficient words over a valid/ready handshake and holds each word on the mux data inputs. It steps the mux select lines through 1 to 48 bit positions, LSB-first or MSB-first, and presents the selected bit as a flow-controlled serial stream with first/last markers. A one-word pending buffer allows back-to-back words with no bubble between them.

## Interface
- `MSB_FIRST`, default 0: 0 = select counts up from 0 to len; 1 = select counts down from len to 0.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  48  packed word; bit k feeds mux input ik.
- `in_len`  in  6  number of bits to send minus one; values above 47 are treated as 47.
- `in_valid`  in  1  word offered.
- `in_ready`  out  1  word can be accepted.
- `hold_data`  out  48  held word, wired to mux inputs i0..i47.
- `sel`  out  8  mux select {s7..s0}; `sel[7:6]` is always 0.
- `mux_out`  in  1  mux output, returned combinationally.
- `ser_bit`  out  1  serial bit; equals `mux_out` with no register.
- `ser_valid`  out  1  `ser_bit` is meaningful.
- `ser_ready`  in  1  downstream accepts the bit.
- `ser_first`  out  1  current bit is the first bit of its word.
- `ser_last`  out  1  current bit is the last bit of its word.
- `busy`  out  1  state is SHIFT or the pending buffer is full.

## Operation
- Handshake terms:
  - Input accept = `in_valid && in_ready`.
  - Bit transfer = `ser_valid && ser_ready`.
- Registers:
  - `hold_data` and `hold_len` (active word).
  - `cnt` (6-bit bit index).
  - `nxt_data`, `nxt_len`, `nxt_full` (pending word).
  - `state` (IDLE or SHIFT).
- Combinational outputs:
  - `in_ready = !nxt_full`.
  - `ser_valid = (state == SHIFT)`.
  - `sel = {2'b00, cnt}`.
- Marker flags:
  - `ser_first` is high when `cnt` equals the start index: 0 if `MSB_FIRST=0`, `hold_len` if `MSB_FIRST=1`.
  - `ser_last` is high when `cnt` equals the end index: `hold_len` if `MSB_FIRST=0`, 0 if `MSB_FIRST=1`.
- IDLE:
  - On input accept: `hold` ← input, `cnt` ← start index, go to SHIFT.
  - `nxt_full` stays 0.
- SHIFT, bit transfer on a bit that is not last: `cnt` steps by +1 (`MSB_FIRST=0`) or -1 (`MSB_FIRST=1`).
- SHIFT, bit transfer on the last bit:
  - If `nxt_full`: `hold` ← `nxt`, `cnt` ← the new start index, `nxt_full` ← 0, stay in SHIFT.
  - Else, if an input is accepted in the same cycle: `hold` ← input (bypass), stay in SHIFT.
  - Else: go to IDLE. `hold_data` keeps its value.
- SHIFT, input accept without a last-bit transfer: `nxt` ← input, `nxt_full` ← 1.
- SHIFT, last-bit transfer and input accept in the same cycle with `nxt_full` = 1: cannot occur, because `in_ready` = 0 when `nxt_full` = 1.
- Stall: when `ser_ready` = 0, `cnt`, `hold`, `sel` and all flags hold their values. `ser_bit` stays stable as long as the mux is combinational.
- `in_len` = 0 gives a single-bit word with `ser_first` = `ser_last` = 1.
- `in_len` is clamped to 47 at capture time, so `sel` never reaches 48..63.
- `sel[7:6]` is held at 0, so the mux's constant-zero leg is never selected.

## Timing
- Reset (`rst_n` = 0 at a clock edge) forces:
  - state = IDLE, `cnt` = 0, `sel` = 0, `hold_data` = 0, `hold_len` = 0, `nxt_full` = 0.
  - Outputs: `ser_valid` = 0, `ser_first` = 0, `ser_last` = 0, `busy` = 0, `in_ready` = 1.
- Reset mid-word discards both the active and the pending word. No partial-word completion is signalled.
- Latency: an accept at edge N from IDLE gives `ser_valid` = 1 with the first bit in cycle N+1.
- Throughput: 1 bit per cycle while `ser_ready` = 1.
- Word boundaries: with a pending word (or a bypass input), the last bit of word A in cycle M is followed by the first bit of word B in cycle M+1, with no bubble.
- `in_ready` falls the cycle after the pending buffer fills. It rises the cycle after the pending buffer is promoted.

## Test plan
- Reset, then send word 0x0000_0000_00A5 with len 7, `MSB_FIRST`=0 and `ser_ready` held at 1:
  - `ser_bit` sequence 1,0,1,0,0,1,0,1 over cycles 1..8.
  - `sel` = 0..7; `ser_first` in cycle 1 only; `ser_last` in cycle 8 only; IDLE after.
- `MSB_FIRST`=1, word 0x8000_0000_0001, len 47:
  - 48 bits, first bit 1 and last bit 1, `sel` counting 47 down to 0.
- Back-to-back: word A (len 3) accepted, word B (len 2) accepted during A's second bit:
  - `in_ready` = 0 until B is promoted.
  - Seven consecutive valid cycles; `ser_last` in cycles 4 and 7.
- Stall: deassert `ser_ready` for 5 cycles at bit 10 of a 48-bit word:
  - `sel` holds at 10 and no bit is lost or duplicated.
  - Total of 53 valid cycles.
- `in_len` = 63 is clamped to 47: exactly 48 bits are sent and `sel` never exceeds 47.
- Assert `rst_n` = 0 mid-word with a pending word present:
  - The next cycle shows `ser_valid` = 0, `in_ready` = 1, `sel` = 0.
  - A following word starts cleanly at bit 0.

Source files
------------

// File: rtl/mux48_serial_ctrl.sv
// rtl/mux48_serial_ctrl.sv - 48-to-1 mux sequencer with one-word pending buffer
module mux48_serial_ctrl #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] in_data,
    input  logic [5:0]  in_len,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [47:0] hold_data,
    output logic [7:0]  sel,
    input  logic        mux_out,
    output logic        ser_bit,
    output logic        ser_valid,
    input  logic        ser_ready,
    output logic        ser_first,
    output logic        ser_last,
    output logic        busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state;
    logic [5:0]  hold_len;
    logic [5:0]  cnt;
    logic [47:0] nxt_data;
    logic [5:0]  nxt_len;
    logic        nxt_full;
    logic [5:0]  in_len_c;
    logic        accept;
    logic        xfer;
    logic        at_last;

    function automatic logic [5:0] start_idx(input logic [5:0] len);
        return MSB_FIRST ? len : 6'd0;
    endfunction

    function automatic logic [5:0] end_idx(input logic [5:0] len);
        return MSB_FIRST ? 6'd0 : len;
    endfunction

    // Clamping at capture keeps sel inside the 48 real mux legs
    assign in_len_c  = (in_len > 6'd47) ? 6'd47 : in_len;

    assign in_ready  = !nxt_full;
    assign ser_valid = (state == SHIFT);
    assign sel       = {2'b00, cnt};
    assign ser_bit   = mux_out;
    assign busy      = (state == SHIFT) || nxt_full;
    assign accept    = in_valid && in_ready;
    assign xfer      = ser_valid && ser_ready;
    assign at_last   = (cnt == end_idx(hold_len));

    // Flags are qualified by SHIFT so an idle controller never shows stale markers
    assign ser_first = ser_valid && (cnt == start_idx(hold_len));
    assign ser_last  = ser_valid && at_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            hold_data <= 48'd0;
            hold_len  <= 6'd0;
            nxt_data  <= 48'd0;
            nxt_len   <= 6'd0;
            nxt_full  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hold_data <= in_data;
                        hold_len  <= in_len_c;
                        cnt       <= start_idx(in_len_c);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (xfer && at_last) begin
                        if (nxt_full) begin
                            hold_data <= nxt_data;
                            hold_len  <= nxt_len;
                            cnt       <= start_idx(nxt_len);
                            nxt_full  <= 1'b0;
                        end else if (accept) begin
                            hold_data <= in_data;
                            hold_len  <= in_len_c;
                            cnt       <= start_idx(in_len_c);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            cnt <= MSB_FIRST ? (cnt - 6'd1) : (cnt + 6'd1);
                        end
                        if (accept) begin
                            nxt_data <= in_data;
                            nxt_len  <= in_len_c;
                            nxt_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux48_serial_ctrl.sv
// tb/tb_mux48_serial_ctrl.sv - randomized and directed checks of mux48_serial_ctrl in both bit orders
module tb_mux48_serial_ctrl;

    typedef struct packed {
        logic       b;
        logic [5:0] sel;
        logic       first;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] in_data;
    logic [5:0]  in_len;
    logic        in_valid;
    logic        ser_ready;
    logic        chk_en;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam bit MSB = (g == 1);
        logic        in_ready;
        logic [47:0] hold_data;
        logic [7:0]  sel;
        logic        mux_out;
        logic        ser_bit;
        logic        ser_valid;
        logic        ser_first;
        logic        ser_last;
        logic        busy;
        logic [63:0] pad;

        assign pad     = {16'd0, hold_data};
        assign mux_out = pad[sel[5:0]] & (sel[7:6] == 2'b00);

        mux48_serial_ctrl #(.MSB_FIRST(MSB)) dut (
            .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_len(in_len),
            .in_valid(in_valid), .in_ready(in_ready), .hold_data(hold_data),
            .sel(sel), .mux_out(mux_out), .ser_bit(ser_bit), .ser_valid(ser_valid),
            .ser_ready(ser_ready), .ser_first(ser_first), .ser_last(ser_last), .busy(busy)
        );

        // Model: a queue of outstanding words and the flat list of bits they still owe
        exp_t        bq[$];
        logic [47:0] wq[$];
        logic [47:0] hexp;
        string       pfx = MSB ? "msb " : "lsb ";

        always @(posedge clk) begin
            if (!rst_n) begin
                bq.delete();
                wq.delete();
                hexp = 48'd0;
            end else begin
                bit   acc;
                bit   xf;
                exp_t e;
                int   len;
                int   idx;
                acc = in_valid && (wq.size() < 2);
                xf  = (bq.size() > 0) && ser_ready;
                if (xf) begin
                    e = bq.pop_front();
                    if (e.last) void'(wq.pop_front());
                end
                if (acc) begin
                    len = (int'(in_len) > 47) ? 47 : int'(in_len);
                    wq.push_back(in_data);
                    for (int i = 0; i <= len; i++) begin
                        idx = MSB ? (len - i) : i;
                        e.b = in_data[idx];
                        e.sel = 6'(idx);
                        e.first = (i == 0);
                        e.last = (i == len);
                        bq.push_back(e);
                    end
                end
                if (wq.size() > 0) hexp = wq[0];
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                chk({pfx, "ser_valid"}, 64'(ser_valid), 64'(bq.size() > 0));
                chk({pfx, "in_ready"}, 64'(in_ready), 64'(wq.size() < 2));
                chk({pfx, "busy"}, 64'(busy), 64'(wq.size() > 0));
                chk({pfx, "hold_data"}, 64'(hold_data), 64'(hexp));
                chk({pfx, "sel_hi"}, 64'(sel[7:6]), 64'd0);
                if (bq.size() > 0) begin
                    chk({pfx, "sel"}, 64'(sel), 64'(bq[0].sel));
                    chk({pfx, "ser_bit"}, 64'(ser_bit), 64'(bq[0].b));
                    chk({pfx, "ser_first"}, 64'(ser_first), 64'(bq[0].first));
                    chk({pfx, "ser_last"}, 64'(ser_last), 64'(bq[0].last));
                end else begin
                    chk({pfx, "idle_first"}, 64'(ser_first), 64'd0);
                    chk({pfx, "idle_last"}, 64'(ser_last), 64'd0);
                end
            end
        end
    end

    task automatic send(input logic [47:0] d, input logic [5:0] l);
        int n;
        @(negedge clk);
        in_data  = d;
        in_len   = l;
        in_valid = 1'b1;
        n = 0;
        while (!u[0].in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 64'd1, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((u[0].busy || u[1].busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_reset_state();
        chk("rst lsb ser_valid", 64'(u[0].ser_valid), 64'd0);
        chk("rst lsb in_ready", 64'(u[0].in_ready), 64'd1);
        chk("rst lsb sel", 64'(u[0].sel), 64'd0);
        chk("rst lsb busy", 64'(u[0].busy), 64'd0);
        chk("rst lsb flags", 64'({u[0].ser_first, u[0].ser_last}), 64'd0);
        chk("rst lsb hold", 64'(u[0].hold_data), 64'd0);
        chk("rst msb ser_valid", 64'(u[1].ser_valid), 64'd0);
        chk("rst msb in_ready", 64'(u[1].in_ready), 64'd1);
        chk("rst msb sel", 64'(u[1].sel), 64'd0);
        chk("rst msb flags", 64'({u[1].ser_first, u[1].ser_last}), 64'd0);
    endtask

    initial begin
        logic [7:0]  bits, fb, lb;
        logic [8:1]  vb, lv, rb;
        logic [47:0] d;
        bit          ok;
        int          vcnt, sc, maxsel;
        bit          stalled;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0;
        ser_ready = 1'b1; chk_en = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        chk_en = 1'b1;
        rst_n = 1'b1;

        // LSB-first 0xA5, len 7
        send(48'h0000_0000_00A5, 6'd7);
        ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            bits[c] = u[0].ser_bit;
            fb[c] = u[0].ser_first;
            lb[c] = u[0].ser_last;
            if (u[0].sel != 8'(c) || !u[0].ser_valid) ok = 1'b0;
        end
        chk("a5 bits", 64'(bits), 64'h a5);
        chk("a5 first", 64'(fb), 64'h01);
        chk("a5 last", 64'(lb), 64'h80);
        chk("a5 sel ramp", 64'(ok), 64'd1);
        @(negedge clk);
        chk("a5 idle after", 64'(u[0].ser_valid), 64'd0);
        wait_idle();

        // MSB-first 48-bit word
        send(48'h8000_0000_0001, 6'd47);
        ok = 1'b1;
        for (int c = 0; c < 48; c++) begin
            if (c > 0) @(negedge clk);
            if (u[1].sel != 8'(47 - c) || !u[1].ser_valid) ok = 1'b0;
            if (c == 0) chk("msb first bit", 64'({u[1].ser_bit, u[1].ser_first}), 64'h3);
            if (c == 47) chk("msb last bit", 64'({u[1].ser_bit, u[1].ser_last}), 64'h3);
        end
        chk("msb sel ramp", 64'(ok), 64'd1);
        @(negedge clk);
        chk("msb idle after", 64'(u[1].ser_valid), 64'd0);
        wait_idle();

        // Back-to-back: A len 3, B len 2 accepted during A's second bit
        @(negedge clk);
        in_data = 48'h5; in_len = 6'd3; in_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            vb[c] = u[0].ser_valid;
            lv[c] = u[0].ser_last;
            rb[c] = u[0].in_ready;
            if (c == 1) in_valid = 1'b0;
            if (c == 2) begin in_data = 48'h6; in_len = 6'd2; in_valid = 1'b1; end
            if (c == 3) in_valid = 1'b0;
        end
        chk("b2b valid", 64'(vb), 64'b0111_1111);
        chk("b2b last", 64'(lv), 64'b0100_1000);
        chk("b2b in_ready", 64'(rb), 64'b1111_0011);
        wait_idle();

        // Stall 5 cycles at bit 10
        d = {$urandom, $urandom};
        send(d, 6'd47);
        vcnt = 0; sc = 0; stalled = 0; ok = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            if (!u[0].ser_valid) break;
            vcnt++;
            if (sc > 0) begin
                if (u[0].sel != 8'd10) ok = 1'b0;
                sc--;
                if (sc == 0) ser_ready = 1'b1;
            end else if (!stalled && u[0].sel == 8'd10) begin
                ser_ready = 1'b0;
                sc = 5;
                stalled = 1'b1;
            end
        end
        ser_ready = 1'b1;
        chk("stall valid cycles", 64'(vcnt), 64'd53);
        chk("stall sel held", 64'(ok), 64'd1);
        wait_idle();

        // Length 63 clamps to 47
        d = {$urandom, $urandom};
        send(d, 6'd63);
        vcnt = 0; maxsel = 0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            if (!u[0].ser_valid) break;
            vcnt++;
            if (int'(u[0].sel) > maxsel) maxsel = int'(u[0].sel);
        end
        chk("clamp bit count", 64'(vcnt), 64'd48);
        chk("clamp max sel", 64'(maxsel), 64'd47);
        wait_idle();

        // Reset mid-word with a pending word
        send(48'hFFFF_0000_FFFF, 6'd47);
        send(48'h1234_5678_9ABC, 6'd10);
        repeat (3) @(negedge clk);
        chk("pending present", 64'({u[0].busy, u[0].in_ready}), 64'b10);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        send(48'h3C, 6'd5);
        chk("post-rst lsb start", 64'({u[0].sel, u[0].ser_first, u[0].ser_bit}), 64'({8'd0, 1'b1, 1'b0}));
        chk("post-rst msb start", 64'({u[1].sel, u[1].ser_first, u[1].ser_bit}), 64'({8'd5, 1'b1, 1'b1}));
        wait_idle();

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            in_valid  = ($urandom % 3) != 0;
            in_data   = {$urandom, $urandom};
            in_len    = (($urandom % 4) == 0) ? 6'($urandom) : 6'($urandom % 6);
            ser_ready = ($urandom % 4) != 0;
            rst_n     = ($urandom % 600) != 0;
        end
        @(negedge clk);
        in_valid = 1'b0; ser_ready = 1'b1; rst_n = 1'b1;
        wait_idle();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
